// File: rtl/fetch_instr_queue.sv
// Dual-port in-order instruction queue between fetch validation and dual-issue decode.
// Accepts up to two instructions per cycle and presents the two oldest entries.
module fetch_instr_queue #(
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic [1:0]    in_vld,
    input  logic [31:0]   in_pc,
    input  logic [63:0]   in_instr,
    output logic          in_ready,
    output logic [1:0]    out_vld,
    output logic [31:0]   out_pc0,
    output logic [31:0]   out_instr0,
    output logic [31:0]   out_pc1,
    output logic [31:0]   out_instr1,
    input  logic [1:0]    out_ready,
    output logic [CW-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]   pc_mem_q    [DEPTH];
    logic [31:0]   instr_mem_q [DEPTH];
    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [AW-1:0] head_p1, tail_p1;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] push_n, pop_n;
    logic          push_en, pop0, pop1;

    // Room for a full dual push is required, so a held fetch word never splits.
    assign in_ready   = (count_q <= CW'(DEPTH - 2));
    assign out_vld[0] = (count_q != '0);
    assign out_vld[1] = (count_q >= CW'(2));
    assign count      = count_q;

    assign head_p1 = head_q + AW'(1);
    assign tail_p1 = tail_q + AW'(1);

    assign out_pc0    = out_vld[0] ? pc_mem_q[head_q]     : '0;
    assign out_instr0 = out_vld[0] ? instr_mem_q[head_q]  : '0;
    assign out_pc1    = out_vld[1] ? pc_mem_q[head_p1]    : '0;
    assign out_instr1 = out_vld[1] ? instr_mem_q[head_p1] : '0;

    assign pop0    = out_vld[0] & out_ready[0];
    assign pop1    = pop0 & out_vld[1] & out_ready[1];
    assign push_en = in_ready & ~flush;

    always_comb begin
        push_n  = '0;
        pop_n   = CW'(pop0) + CW'(pop1);
        if (push_en) begin
            push_n = CW'(in_vld[0]) + CW'(in_vld[1]);
        end
        head_d  = head_q + AW'(pop0) + AW'(pop1);
        tail_d  = tail_q + push_n[AW-1:0];
        count_d = count_q + push_n - pop_n;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage carries no reset; occupancy alone qualifies its contents.
    always_ff @(posedge clk) begin
        if (push_en) begin
            case (in_vld)
                2'b11: begin
                    pc_mem_q[tail_q]     <= in_pc;
                    instr_mem_q[tail_q]  <= in_instr[31:0];
                    pc_mem_q[tail_p1]    <= in_pc + 32'd4;
                    instr_mem_q[tail_p1] <= in_instr[63:32];
                end
                2'b10: begin
                    pc_mem_q[tail_q]    <= in_pc;
                    instr_mem_q[tail_q] <= in_instr[63:32];
                end
                2'b01: begin
                    pc_mem_q[tail_q]    <= in_pc;
                    instr_mem_q[tail_q] <= in_instr[31:0];
                end
                default: ;
            endcase
        end
    end

    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
        count_q <= CW'(DEPTH));
    a_ptr_consistent: assert property (@(posedge clk) disable iff (!rst_n)
        (tail_q - head_q) == count_q[AW-1:0]);

endmodule

// File: tb/tb_fetch_instr_queue.sv
// Bench for fetch_instr_queue: directed scenarios plus random traffic against a queue model.
module tb_fetch_instr_queue;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic [1:0]    in_vld = 2'b00;
    logic [31:0]   in_pc = '0;
    logic [63:0]   in_instr = '0;
    logic          in_ready;
    logic [1:0]    out_vld;
    logic [31:0]   out_pc0, out_instr0, out_pc1, out_instr1;
    logic [1:0]    out_ready = 2'b00;
    logic [CW-1:0] count;

    int n_cmp = 0;
    int n_err = 0;

    // Model: queue of {pc, instr}, oldest at index 0.
    logic [63:0] m_q[$];

    fetch_instr_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_vld(in_vld), .in_pc(in_pc), .in_instr(in_instr), .in_ready(in_ready),
        .out_vld(out_vld), .out_pc0(out_pc0), .out_instr0(out_instr0),
        .out_pc1(out_pc1), .out_instr1(out_instr1),
        .out_ready(out_ready), .count(count)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        int  sz;
        int  npop;
        bit  rdy;
        sz  = m_q.size();
        rdy = (DEPTH - sz) >= 2;
        if (flush) begin
            m_q.delete();
            return;
        end
        npop = 0;
        if (sz >= 1 && out_ready[0]) begin
            npop = 1;
            if (sz >= 2 && out_ready[1]) npop = 2;
        end
        for (int i = 0; i < npop; i++) void'(m_q.pop_front());
        if (rdy) begin
            case (in_vld)
                2'b11: begin
                    m_q.push_back({in_pc, in_instr[31:0]});
                    m_q.push_back({in_pc + 32'd4, in_instr[63:32]});
                end
                2'b10: m_q.push_back({in_pc, in_instr[63:32]});
                2'b01: m_q.push_back({in_pc, in_instr[31:0]});
                default: ;
            endcase
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [31:0] pc, input logic [63:0] ins,
                         input logic [1:0] ordy, input logic fl);
        in_vld = v; in_pc = pc; in_instr = ins; out_ready = ordy; flush = fl;
    endtask

    task automatic idle();
        drive(2'b00, 32'h0, 64'h0, 2'b00, 1'b0);
    endtask

    task automatic do_flush();
        drive(2'b00, 32'h0, 64'h0, 2'b00, 1'b1);
        tick();
        idle();
    endtask

    function automatic logic [31:0] m_pc(int k);
        return (m_q.size() > k) ? m_q[k][63:32] : 32'h0;
    endfunction

    function automatic logic [31:0] m_ins(int k);
        return (m_q.size() > k) ? m_q[k][31:0] : 32'h0;
    endfunction

    task automatic test_reset();
        n_cmp++; if (count !== '0)        begin n_err++; $display("FAIL rst_init_count got %0d exp 0", count); end
        n_cmp++; if (out_vld !== 2'b00)   begin n_err++; $display("FAIL rst_init_vld got %b exp 00", out_vld); end
        n_cmp++; if (in_ready !== 1'b1)   begin n_err++; $display("FAIL rst_init_ready got %b exp 1", in_ready); end
        drive(2'b11, 32'h40, {32'h2222_2222, 32'h1111_1111}, 2'b00, 1'b0);
        tick();
        idle();
        tick();
        n_cmp++; if (count !== CW'(2))    begin n_err++; $display("FAIL rst_pre_count got %0d exp 2", count); end
        #2;
        rst_n = 1'b0;
        #1;
        m_q.delete();
        n_cmp++; if (count !== '0)        begin n_err++; $display("FAIL rst_async_count got %0d exp 0", count); end
        n_cmp++; if (out_vld !== 2'b00)   begin n_err++; $display("FAIL rst_async_vld got %b exp 00", out_vld); end
        n_cmp++; if (in_ready !== 1'b1)   begin n_err++; $display("FAIL rst_async_ready got %b exp 1", in_ready); end
        n_cmp++; if (out_pc0 !== 32'h0)   begin n_err++; $display("FAIL rst_async_pc0 got %h exp 0", out_pc0); end
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_dual_push();
        drive(2'b11, 32'h100, 64'hBBBBBBBB_AAAAAAAA, 2'b00, 1'b0);
        tick();
        idle();
        n_cmp++; if (out_vld !== 2'b11)          begin n_err++; $display("FAIL dual_vld got %b exp 11", out_vld); end
        n_cmp++; if (count !== CW'(2))           begin n_err++; $display("FAIL dual_count got %0d exp 2", count); end
        n_cmp++; if (out_pc0 !== 32'h100)        begin n_err++; $display("FAIL dual_pc0 got %h exp 100", out_pc0); end
        n_cmp++; if (out_instr0 !== 32'hAAAAAAAA) begin n_err++; $display("FAIL dual_instr0 got %h exp aaaaaaaa", out_instr0); end
        n_cmp++; if (out_pc1 !== 32'h104)        begin n_err++; $display("FAIL dual_pc1 got %h exp 104", out_pc1); end
        n_cmp++; if (out_instr1 !== 32'hBBBBBBBB) begin n_err++; $display("FAIL dual_instr1 got %h exp bbbbbbbb", out_instr1); end
        do_flush();
    endtask

    task automatic test_single_upper();
        drive(2'b10, 32'h10C, 64'hCCCCCCCC_12345678, 2'b00, 1'b0);
        tick();
        idle();
        n_cmp++; if (out_vld !== 2'b01)          begin n_err++; $display("FAIL upper_vld got %b exp 01", out_vld); end
        n_cmp++; if (out_pc0 !== 32'h10C)        begin n_err++; $display("FAIL upper_pc0 got %h exp 10c", out_pc0); end
        n_cmp++; if (out_instr0 !== 32'hCCCCCCCC) begin n_err++; $display("FAIL upper_instr0 got %h exp cccccccc", out_instr0); end
        n_cmp++; if (count !== CW'(1))           begin n_err++; $display("FAIL upper_count got %0d exp 1", count); end
        n_cmp++; if (out_pc1 !== 32'h0)          begin n_err++; $display("FAIL upper_pc1_zero got %h exp 0", out_pc1); end
        do_flush();
    endtask

    task automatic test_fill_backpressure();
        for (int i = 0; i < 4; i++) begin
            drive(2'b11, 32'h100 + 32'(8 * i), {$urandom, $urandom}, 2'b00, 1'b0);
            tick();
        end
        n_cmp++; if (count !== CW'(8))     begin n_err++; $display("FAIL fill_count got %0d exp 8", count); end
        n_cmp++; if (in_ready !== 1'b0)    begin n_err++; $display("FAIL fill_ready got %b exp 0", in_ready); end
        drive(2'b11, 32'h120, {$urandom, $urandom}, 2'b00, 1'b0);
        tick();
        n_cmp++; if (count !== CW'(8))     begin n_err++; $display("FAIL fill_drop_count got %0d exp 8", count); end
        drive(2'b00, 32'h0, 64'h0, 2'b01, 1'b0);
        tick();
        n_cmp++; if (count !== CW'(7))     begin n_err++; $display("FAIL fill_pop1_count got %0d exp 7", count); end
        n_cmp++; if (in_ready !== 1'b0)    begin n_err++; $display("FAIL fill_pop1_ready got %b exp 0", in_ready); end
        n_cmp++; if (out_pc0 !== 32'h104)  begin n_err++; $display("FAIL fill_pop1_pc0 got %h exp 104", out_pc0); end
        drive(2'b00, 32'h0, 64'h0, 2'b11, 1'b0);
        tick();
        idle();
        n_cmp++; if (count !== CW'(5))     begin n_err++; $display("FAIL fill_pop2_count got %0d exp 5", count); end
        n_cmp++; if (in_ready !== 1'b1)    begin n_err++; $display("FAIL fill_pop2_ready got %b exp 1", in_ready); end
        n_cmp++; if (out_pc0 !== 32'h10C)  begin n_err++; $display("FAIL fill_pop2_pc0 got %h exp 10c", out_pc0); end
        // Drain the rest and confirm the dropped pc 0x120 never shows up.
        for (int i = 0; i < 3; i++) begin
            drive(2'b00, 32'h0, 64'h0, 2'b11, 1'b0);
            tick();
        end
        idle();
        n_cmp++; if (count !== '0)         begin n_err++; $display("FAIL fill_drain_count got %0d exp 0", count); end
    endtask

    task automatic test_wrap_concurrent();
        do_flush();
        drive(2'b11, 32'h200, {$urandom, $urandom}, 2'b00, 1'b0);
        tick();
        for (int i = 0; i < 12; i++) begin
            drive(2'b11, 32'h208 + 32'(8 * i), {$urandom, $urandom}, 2'b11, 1'b0);
            tick();
            n_cmp++; if (count !== CW'(2)) begin n_err++; $display("FAIL wrap_count cyc %0d got %0d exp 2", i, count); end
            n_cmp++; if (out_pc0 !== 32'h208 + 32'(8 * i))
                begin n_err++; $display("FAIL wrap_pc0 cyc %0d got %h exp %h", i, out_pc0, 32'h208 + 32'(8 * i)); end
            n_cmp++; if (out_pc1 !== 32'h20C + 32'(8 * i))
                begin n_err++; $display("FAIL wrap_pc1 cyc %0d got %h exp %h", i, out_pc1, 32'h20C + 32'(8 * i)); end
            n_cmp++; if (out_instr0 !== m_ins(0))
                begin n_err++; $display("FAIL wrap_instr0 cyc %0d got %h exp %h", i, out_instr0, m_ins(0)); end
        end
        drive(2'b11, 32'h268, {$urandom, $urandom}, 2'b10, 1'b0);
        tick();
        idle();
        n_cmp++; if (count !== CW'(4))     begin n_err++; $display("FAIL wrap_nopop_count got %0d exp 4", count); end
        n_cmp++; if (out_pc0 !== 32'h260)  begin n_err++; $display("FAIL wrap_nopop_pc0 got %h exp 260", out_pc0); end
    endtask

    task automatic test_flush();
        drive(2'b01, 32'h270, {$urandom, $urandom}, 2'b00, 1'b0);
        tick();
        n_cmp++; if (count !== CW'(5))     begin n_err++; $display("FAIL flush_pre_count got %0d exp 5", count); end
        drive(2'b11, 32'h280, {$urandom, $urandom}, 2'b11, 1'b1);
        tick();
        n_cmp++; if (count !== '0)         begin n_err++; $display("FAIL flush_count got %0d exp 0", count); end
        n_cmp++; if (out_vld !== 2'b00)    begin n_err++; $display("FAIL flush_vld got %b exp 00", out_vld); end
        n_cmp++; if (in_ready !== 1'b1)    begin n_err++; $display("FAIL flush_ready got %b exp 1", in_ready); end
        drive(2'b01, 32'h300, 64'h0BADF00D_DEADBEEF, 2'b00, 1'b0);
        tick();
        idle();
        n_cmp++; if (out_pc0 !== 32'h300)        begin n_err++; $display("FAIL flush_after_pc0 got %h exp 300", out_pc0); end
        n_cmp++; if (out_instr0 !== 32'hDEADBEEF) begin n_err++; $display("FAIL flush_after_instr0 got %h exp deadbeef", out_instr0); end
        n_cmp++; if (count !== CW'(1))           begin n_err++; $display("FAIL flush_after_count got %0d exp 1", count); end
        do_flush();
    endtask

    task automatic test_pc_wrap();
        drive(2'b11, 32'hFFFF_FFFC, 64'h55555555_44444444, 2'b00, 1'b0);
        tick();
        idle();
        n_cmp++; if (out_pc0 !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL pcwrap_pc0 got %h exp fffffffc", out_pc0); end
        n_cmp++; if (out_pc1 !== 32'h0)         begin n_err++; $display("FAIL pcwrap_pc1 got %h exp 0", out_pc1); end
        do_flush();
    endtask

    task automatic test_random();
        logic [1:0] exp_vld;
        for (int c = 0; c < 400; c++) begin
            drive(2'($urandom_range(0, 3)),
                  ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC),
                  {$urandom, $urandom},
                  2'($urandom_range(0, 3)),
                  ($urandom_range(0, 19) == 0));
            tick();
            exp_vld = {m_q.size() >= 2, m_q.size() >= 1};
            n_cmp++; if (count !== CW'(m_q.size()))
                begin n_err++; $display("FAIL rnd_count cyc %0d got %0d exp %0d", c, count, m_q.size()); end
            n_cmp++; if (out_vld !== exp_vld)
                begin n_err++; $display("FAIL rnd_vld cyc %0d got %b exp %b", c, out_vld, exp_vld); end
            n_cmp++; if (in_ready !== ((DEPTH - m_q.size()) >= 2))
                begin n_err++; $display("FAIL rnd_ready cyc %0d got %b exp %b", c, in_ready, (DEPTH - m_q.size()) >= 2); end
            n_cmp++; if (out_pc0 !== m_pc(0))
                begin n_err++; $display("FAIL rnd_pc0 cyc %0d got %h exp %h", c, out_pc0, m_pc(0)); end
            n_cmp++; if (out_instr0 !== m_ins(0))
                begin n_err++; $display("FAIL rnd_instr0 cyc %0d got %h exp %h", c, out_instr0, m_ins(0)); end
            n_cmp++; if (out_pc1 !== m_pc(1))
                begin n_err++; $display("FAIL rnd_pc1 cyc %0d got %h exp %h", c, out_pc1, m_pc(1)); end
            n_cmp++; if (out_instr1 !== m_ins(1))
                begin n_err++; $display("FAIL rnd_instr1 cyc %0d got %h exp %h", c, out_instr1, m_ins(1)); end
        end
        idle();
    endtask

    initial begin
        #12;
        rst_n = 1'b1;
        test_reset();
        test_dual_push();
        test_single_upper();
        test_fill_backpressure();
        test_wrap_concurrent();
        test_flush();
        test_pc_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_instr_queue.md
Name: fetch_instr_queue

Overview:
- Instruction buffer directly downstream of the fetch validation stage.
- Accepts 0, 1 or 2 validated instructions per cycle (pc, 64-bit fetch word, 2-bit valid), stores them in program order, and presents up to 2 oldest instructions per cycle to the dual-issue decode stage.
- Decouples fetch from decode stalls.
- Flush input discards all contents on branch redirect.

Parameters:
- DEPTH, 8, number of instruction entries; power of 2, >= 4.
- CW, $clog2(DEPTH)+1, width of occupancy count.

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of all entries.
- in_vld  input  2  per-slot valid from validation stage (bit0 = lower word, bit1 = upper word).
- in_pc  input  32  pc of first valid instruction in the fetch word.
- in_instr  input  64  fetch word; [31:0] lower slot, [63:32] upper slot.
- in_ready  output  1  queue can accept a push this cycle.
- out_vld  output  2  bit0 = head entry valid, bit1 = head+1 valid.
- out_pc0  output  32  pc of head entry.
- out_instr0  output  32  instruction of head entry.
- out_pc1  output  32  pc of head+1 entry.
- out_instr1  output  32  instruction of head+1 entry.
- out_ready  input  2  decode acceptance per output slot.
- count  output  CW  current occupancy.

Behaviour:
- Storage: DEPTH entries of {pc[31:0], instr[31:0]}; head/tail pointers wrap modulo DEPTH.
- Reset (rst_n low, asynchronous):
  - head=tail=0, count=0.
  - out_vld=00, in_ready=1.
  - out_pc*/out_instr* = 0.
  - Storage array is not reset.
- in_ready = (DEPTH - count) >= 2. Combinational from registered count only; never depends on same-cycle pop.
- Push, taken only when in_ready=1 and flush=0:
  - in_vld=11: entry {in_pc, in_instr[31:0]} then {in_pc+4, in_instr[63:32]}; 2 entries. in_pc+4 wraps mod 2^32.
  - in_vld=10: one entry {in_pc, in_instr[63:32]}.
  - in_vld=01: one entry {in_pc, in_instr[31:0]}.
  - in_vld=00: no entries.
  - Push while in_ready=0 is dropped silently. Fetch must hold it.
- Output valids: out_vld[0] = (count>=1), out_vld[1] = (count>=2).
- Output data:
  - out_pc0/out_instr0 read head combinationally; out_pc1/out_instr1 read head+1 (wrapped).
  - Each data output is forced to 0 when its out_vld bit is 0.
- Pop, in-order prefix only:
  - pop0 = out_vld[0] & out_ready[0].
  - pop1 = pop0 & out_vld[1] & out_ready[1].
  - out_ready=10 pops nothing. Pop count = pop0+pop1.
- Latency: a push at edge N is visible on out_vld after edge N (1 cycle). No input-to-output bypass.
- Simultaneous push and pop in one cycle:
  - count_next = count + push_n - pop_n.
  - Both pointers advance independently.
  - Legal at full-2 and at empty (pop of 0 at empty).
- Flush has highest priority:
  - Next edge: head=tail=0, count=0, out_vld=00.
  - Same-cycle push and pop are discarded.
- rst_n asserted mid-operation: immediate clear, regardless of clk.
- Invariants (assertion targets):
  - count <= DEPTH.
  - tail == head + count (mod DEPTH).
  - Program order of pcs preserved across wrap.

Test Plan:
- Reset: drive rst_n=0 asynchronously mid-cycle -> out_vld=00, count=0, in_ready=1, out_pc0=0 immediately.
- Dual push: in_vld=11, in_pc=0x100, in_instr=0xBBBBBBBB_AAAAAAAA, out_ready=00 -> next cycle:
  - out_vld=11, count=2.
  - out_pc0=0x100, out_instr0=0xAAAAAAAA.
  - out_pc1=0x104, out_instr1=0xBBBBBBBB.
- Single upper push into empty queue: in_vld=10, in_pc=0x10C, in_instr[63:32]=0xCCCCCCCC -> out_vld=01, out_pc0=0x10C, out_instr0=0xCCCCCCCC, count=1.
- Fill and backpressure (DEPTH=8):
  - Four 11 pushes, no pop -> count=8, in_ready=0.
  - Fifth push (pc 0x120) dropped.
  - out_ready=01 -> count=7, in_ready still 0.
  - out_ready=11 -> count=5, in_ready=1; head pc advances 0x100 -> 0x104 -> 0x10C.
- Wrap and concurrency: 12 cycles with in_vld=11 (pc +8 each) and out_ready=11, after one priming push -> count constant 2; output pcs strictly sequential +4 across pointer wrap; out_ready=10 on one cycle -> no pop, count=4.
- Flush with concurrent push and pop (count=5, in_vld=11, out_ready=11, flush=1) -> next cycle count=0, out_vld=00, in_ready=1; a push the following cycle appears at head.
